// File: rtl/eth_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_pkg
//  Description : Shared constants and types for the Ethernet receive frame
//                checker and its CRC32 datapath.
//                Holds the preamble/SFD byte codes, the reflected CRC-32
//                constants, the receive state enum and the per-frame status
//                record.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_rx_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   // Reflected CRC-32 (IEEE 802.3), processed LSB first
   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   // Raw register value left after running a correct frame plus its FCS
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_DROP     = 2'd3
   } rx_state_e;

   typedef struct packed {
      logic        ok;
      logic        crc;
      logic        runt;
      logic        giant;
      logic [15:0] len;
   } frame_status_t;

endpackage
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_d8
//  Description : Combinational CRC-32 next-state function, one byte per call.
//                Reflected polynomial, data consumed LSB first. No init or
//                final inversion is applied here; the caller owns the
//                register. Also intended for the TX FCS inserter.
//  Ports       : crc_in   [31:0] in  current CRC register
//                data_in  [7:0]  in  byte to absorb
//                crc_out  [31:0] out CRC register after the byte
//  Revision    : 1.0 - initial release
// ============================================================================
module crc32_d8
   import eth_rx_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [31:0] crc_out
);

   logic [31:0] crc_v;

   always_comb begin
      crc_v = crc_in;
      for (int i = 0; i < 8; i++) begin
         crc_v = {1'b0, crc_v[31:1]} ^ ((crc_v[0] ^ data_in[i]) ? CRC32_POLY : 32'h0);
      end
      crc_out = crc_v;
   end

endmodule
`default_nettype wire

// File: rtl/eth_rx_frame_check.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_frame_check
//  Description : GMII-style receive frame checker. Locates preamble + SFD,
//                streams the frame body with the 4-byte FCS stripped,
//                checks CRC-32 and length, and reports per-frame status.
//  Build macro : ETH_RX_CHECK_STATS_EN - when defined, the good/bad/preamble
//                error statistics counters are built; otherwise those ports
//                are tied to zero.
//  Ports       : clk          in   clock
//                nrst         in   synchronous active-low reset
//                rx_dv / rxd  in   input byte stream and its valid
//                out_valid    out  out_data carries a payload byte
//                out_data     out  payload byte (FCS excluded)
//                out_sop      out  first payload byte of a frame
//                frame_done   out  one-cycle end-of-frame pulse
//                frame_ok, crc_err, runt_err, giant_err  out  frame status
//                frame_len    out  bytes after SFD incl. FCS, saturating
//                good_cnt, bad_cnt, pre_err_cnt          out  statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_frame_check
   import eth_rx_pkg::*;
#(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518,
   parameter int CNT_W     = 16
)
(
   input  logic             clk,
   input  logic             nrst,
   input  logic             rx_dv,
   input  logic [7:0]       rxd,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_sop,
   output logic             frame_done,
   output logic             frame_ok,
   output logic             crc_err,
   output logic             runt_err,
   output logic             giant_err,
   output logic [15:0]      frame_len,
   output logic [CNT_W-1:0] good_cnt,
   output logic [CNT_W-1:0] bad_cnt,
   output logic [CNT_W-1:0] pre_err_cnt
);

   localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
   localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);

   rx_state_e     state_q, state_d;
   logic [31:0]   crc_q, crc_d, crc_next;
   logic [15:0]   len_q, len_d, len_inc;
   // Four-byte delay line: newest byte enters at [7:0], oldest leaves at [31:24]
   logic [31:0]   dly_q, dly_d;
   logic [2:0]    dly_cnt_q, dly_cnt_d;
   logic          sop_pend_q, sop_pend_d;
   logic          out_valid_q, out_valid_d;
   logic [7:0]    out_data_q, out_data_d;
   logic          out_sop_q, out_sop_d;
   logic          frame_done_q, frame_done_d;
   frame_status_t status_q, status_d;

   logic          frame_end;
   logic          crc_bad;
   logic          is_runt;
   logic          is_giant;
   logic          frame_good;

   crc32_d8 u_crc32_d8 (
      .crc_in  (crc_q),
      .data_in (rxd),
      .crc_out (crc_next)
   );

   assign len_inc    = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
   assign frame_end  = (state_q == ST_DATA) && !rx_dv;
   assign crc_bad    = (crc_q != CRC32_RESIDUE);
   assign is_runt    = (len_q < MIN_LEN);
   assign is_giant   = (len_q > MAX_LEN);
   assign frame_good = !(crc_bad || is_runt || is_giant);

   always_comb begin
      state_d      = state_q;
      crc_d        = crc_q;
      len_d        = len_q;
      dly_d        = dly_q;
      dly_cnt_d    = dly_cnt_q;
      sop_pend_d   = sop_pend_q;
      out_valid_d  = 1'b0;
      out_data_d   = out_data_q;
      out_sop_d    = 1'b0;
      frame_done_d = 1'b0;
      status_d     = status_q;

      case (state_q)
         ST_IDLE: begin
            if (rx_dv) begin
               state_d = (rxd == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
            end
         end

         ST_PREAMBLE: begin
            if (!rx_dv) begin
               state_d = ST_IDLE;
            end else if (rxd == SFD_BYTE) begin
               state_d    = ST_DATA;
               crc_d      = CRC32_INIT;
               len_d      = 16'd0;
               dly_cnt_d  = 3'd0;
               sop_pend_d = 1'b1;
            end else if (rxd != PREAMBLE_BYTE) begin
               state_d = ST_DROP;
            end
         end

         ST_DATA: begin
            if (rx_dv) begin
               crc_d = crc_next;
               len_d = len_inc;
               dly_d = {dly_q[23:0], rxd};
               // Only once four bytes are buffered is the oldest one known
               // not to be part of the FCS.
               if (dly_cnt_q == 3'd4) begin
                  out_valid_d = 1'b1;
                  out_data_d  = dly_q[31:24];
                  out_sop_d   = sop_pend_q;
                  sop_pend_d  = 1'b0;
               end else begin
                  dly_cnt_d = dly_cnt_q + 3'd1;
               end
            end else begin
               // End of frame: the buffered bytes are the FCS and are dropped
               state_d        = ST_IDLE;
               frame_done_d   = 1'b1;
               status_d.ok    = frame_good;
               status_d.crc   = crc_bad;
               status_d.runt  = is_runt;
               status_d.giant = is_giant;
               status_d.len   = len_q;
               dly_d          = 32'h0;
               dly_cnt_d      = 3'd0;
               sop_pend_d     = 1'b0;
            end
         end

         ST_DROP: begin
            if (!rx_dv) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q      <= ST_IDLE;
         crc_q        <= CRC32_INIT;
         len_q        <= 16'd0;
         dly_q        <= 32'h0;
         dly_cnt_q    <= 3'd0;
         sop_pend_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= 8'h00;
         out_sop_q    <= 1'b0;
         frame_done_q <= 1'b0;
         status_q     <= '0;
      end else begin
         state_q      <= state_d;
         crc_q        <= crc_d;
         len_q        <= len_d;
         dly_q        <= dly_d;
         dly_cnt_q    <= dly_cnt_d;
         sop_pend_q   <= sop_pend_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_sop_q    <= out_sop_d;
         frame_done_q <= frame_done_d;
         status_q     <= status_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_sop    = out_sop_q;
   assign frame_done = frame_done_q;
   assign frame_ok   = status_q.ok;
   assign crc_err    = status_q.crc;
   assign runt_err   = status_q.runt;
   assign giant_err  = status_q.giant;
   assign frame_len  = status_q.len;

`ifdef ETH_RX_CHECK_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
   logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
   logic [CNT_W-1:0] pre_err_cnt_q, pre_err_cnt_d;
   logic             pre_err;

   always_comb begin
      // Any byte that is neither a valid preamble continuation nor the SFD
      // sends the receiver into DROP and counts as a preamble error.
      pre_err = rx_dv &&
                (((state_q == ST_IDLE) && (rxd != PREAMBLE_BYTE)) ||
                 ((state_q == ST_PREAMBLE) && (rxd != PREAMBLE_BYTE) && (rxd != SFD_BYTE)));
      good_cnt_d    = good_cnt_q;
      bad_cnt_d     = bad_cnt_q;
      pre_err_cnt_d = pre_err_cnt_q;
      if (frame_end && frame_good) begin
         good_cnt_d = good_cnt_q + CNT_ONE;
      end
      if (frame_end && !frame_good) begin
         bad_cnt_d = bad_cnt_q + CNT_ONE;
      end
      if (pre_err) begin
         pre_err_cnt_d = pre_err_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         good_cnt_q    <= '0;
         bad_cnt_q     <= '0;
         pre_err_cnt_q <= '0;
      end else begin
         good_cnt_q    <= good_cnt_d;
         bad_cnt_q     <= bad_cnt_d;
         pre_err_cnt_q <= pre_err_cnt_d;
      end
   end

   assign good_cnt    = good_cnt_q;
   assign bad_cnt     = bad_cnt_q;
   assign pre_err_cnt = pre_err_cnt_q;
`else
   assign good_cnt    = '0;
   assign bad_cnt     = '0;
   assign pre_err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_check.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_rx_frame_check
//  Description : Self-checking bench for eth_rx_frame_check. Expected payload
//                bytes and frame status are queued as stimulus is driven and
//                compared as the checker produces them.
//                Honours ETH_RX_CHECK_STATS_EN for the counter expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_frame_check;

`ifdef ETH_RX_CHECK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
   } exp_byte_t;

   typedef struct packed {
      logic        ok;
      logic        crc;
      logic        runt;
      logic        giant;
      logic [15:0] len;
      logic [15:0] good;
      logic [15:0] bad;
      logic [15:0] pre;
   } exp_stat_t;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        rx_dv = 1'b0;
   logic [7:0]  rxd = 8'h00;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_sop;
   logic        frame_done;
   logic        frame_ok;
   logic        crc_err;
   logic        runt_err;
   logic        giant_err;
   logic [15:0] frame_len;
   logic [15:0] good_cnt;
   logic [15:0] bad_cnt;
   logic [15:0] pre_err_cnt;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] m_good = 16'd0;
   logic [15:0] m_bad  = 16'd0;
   logic [15:0] m_pre  = 16'd0;

   logic [7:0]  fbuf[$];
   exp_byte_t   exp_q[$];
   exp_stat_t   st_q[$];

   always #5 clk = ~clk;

   eth_rx_frame_check dut (
      .clk         (clk),
      .nrst        (nrst),
      .rx_dv       (rx_dv),
      .rxd         (rxd),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_sop     (out_sop),
      .frame_done  (frame_done),
      .frame_ok    (frame_ok),
      .crc_err     (crc_err),
      .runt_err    (runt_err),
      .giant_err   (giant_err),
      .frame_len   (frame_len),
      .good_cnt    (good_cnt),
      .bad_cnt     (bad_cnt),
      .pre_err_cnt (pre_err_cnt)
   );

   // Byte-at-a-time reflected CRC-32 reference
   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   task automatic drive(input logic v, input logic [7:0] b, input logic r);
      @(posedge clk);
      #1;
      rx_dv = v;
      rxd   = b;
      nrst  = r;
   endtask

   task automatic fill_payload(input int n, input int seed);
      fbuf.delete();
      for (int i = 0; i < n; i++) begin
         fbuf.push_back(8'(seed + i * 37));
      end
   endtask

   task automatic append_fcs();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (fbuf[i]) c = crc_upd(c, fbuf[i]);
      c = ~c;
      fbuf.push_back(c[7:0]);
      fbuf.push_back(c[15:8]);
      fbuf.push_back(c[23:16]);
      fbuf.push_back(c[31:24]);
   endtask

   task automatic build_gen_frame(input int seed);
      fill_payload(60, seed);
      fbuf[0]  = 8'hD8;
      fbuf[10] = 8'h2E;
      fbuf[59] = 8'h01;
      append_fcs();
   endtask

   // Drives preamble, SFD and fbuf, then 'gap' idle cycles; queues the
   // expected payload bytes and the expected end-of-frame status.
   task automatic send_frame(input int gap);
      int          n;
      logic [31:0] c;
      exp_byte_t   e;
      exp_stat_t   s;
      n = fbuf.size();
      repeat (7) drive(1'b1, 8'h55, 1'b1);
      drive(1'b1, 8'hD5, 1'b1);
      for (int k = 0; k < n; k++) begin
         if (k >= 4) begin
            e.data = fbuf[k-4];
            e.sop  = (k == 4);
            exp_q.push_back(e);
         end
         drive(1'b1, fbuf[k], 1'b1);
      end
      c = 32'hFFFFFFFF;
      foreach (fbuf[i]) c = crc_upd(c, fbuf[i]);
      s.crc   = (c != 32'hDEBB20E3);
      s.len   = (n > 65535) ? 16'hFFFF : 16'(n);
      s.runt  = (n < 64);
      s.giant = (n > 1518);
      s.ok    = !(s.crc || s.runt || s.giant);
      if (s.ok) m_good = m_good + 16'd1;
      else      m_bad  = m_bad + 16'd1;
      s.good = m_good;
      s.bad  = m_bad;
      s.pre  = m_pre;
      st_q.push_back(s);
      repeat (gap) drive(1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_reset();
      nrst  = 1'b0;
      rx_dv = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec += 12;
      if (out_valid !== 1'b0)    begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      if (out_data !== 8'h00)    begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
      if (out_sop !== 1'b0)      begin n_err++; $display("FAIL reset_out_sop: got %b want 0", out_sop); end
      if (frame_done !== 1'b0)   begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      if (frame_ok !== 1'b0)     begin n_err++; $display("FAIL reset_frame_ok: got %b want 0", frame_ok); end
      if (crc_err !== 1'b0)      begin n_err++; $display("FAIL reset_crc_err: got %b want 0", crc_err); end
      if (runt_err !== 1'b0)     begin n_err++; $display("FAIL reset_runt_err: got %b want 0", runt_err); end
      if (giant_err !== 1'b0)    begin n_err++; $display("FAIL reset_giant_err: got %b want 0", giant_err); end
      if (frame_len !== 16'h0)   begin n_err++; $display("FAIL reset_frame_len: got %h want 0000", frame_len); end
      if (good_cnt !== 16'h0)    begin n_err++; $display("FAIL reset_good_cnt: got %h want 0000", good_cnt); end
      if (bad_cnt !== 16'h0)     begin n_err++; $display("FAIL reset_bad_cnt: got %h want 0000", bad_cnt); end
      if (pre_err_cnt !== 16'h0) begin n_err++; $display("FAIL reset_pre_err_cnt: got %h want 0000", pre_err_cnt); end
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_good_frame();
      build_gen_frame(3);
      send_frame(3);
      repeat (4) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0 || st_q.size() != 0) begin
         n_err++;
         $display("FAIL good_drain: got %0d bytes/%0d status pending, want 0/0", exp_q.size(), st_q.size());
      end
   endtask

   task automatic test_crc_error();
      build_gen_frame(3);
      fbuf[10] = 8'h2F;
      send_frame(3);
      repeat (4) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0 || st_q.size() != 0) begin
         n_err++;
         $display("FAIL crc_drain: got %0d bytes/%0d status pending, want 0/0", exp_q.size(), st_q.size());
      end
   endtask

   task automatic test_runt();
      fill_payload(16, 77);
      append_fcs();
      send_frame(2);
      fill_payload(59, 5);       // 63 bytes with FCS: one short of legal
      append_fcs();
      send_frame(2);
      fill_payload(3, 9);        // shorter than the delay line: no payload out
      send_frame(2);
      repeat (4) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0 || st_q.size() != 0) begin
         n_err++;
         $display("FAIL runt_drain: got %0d bytes/%0d status pending, want 0/0", exp_q.size(), st_q.size());
      end
   endtask

   task automatic test_giant();
      fill_payload(1514, 21);    // exactly MAX_FRAME with FCS
      append_fcs();
      send_frame(2);
      fill_payload(1516, 22);    // two bytes over
      append_fcs();
      send_frame(2);
      repeat (4) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0 || st_q.size() != 0) begin
         n_err++;
         $display("FAIL giant_drain: got %0d bytes/%0d status pending, want 0/0", exp_q.size(), st_q.size());
      end
   endtask

   task automatic test_preamble_error();
      drive(1'b1, 8'h55, 1'b1);
      drive(1'b1, 8'h55, 1'b1);
      drive(1'b1, 8'h5D, 1'b1);
      m_pre = m_pre + 16'd1;
      for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'hD5 + i), 1'b1);
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      n_vec += 2;
      if (pre_err_cnt !== (STATS ? m_pre : 16'h0)) begin
         n_err++;
         $display("FAIL pre_err_cnt: got %h want %h", pre_err_cnt, STATS ? m_pre : 16'h0);
      end
      if (exp_q.size() != 0 || st_q.size() != 0) begin
         n_err++;
         $display("FAIL pre_drain: got %0d bytes/%0d status pending, want 0/0", exp_q.size(), st_q.size());
      end
      build_gen_frame(40);
      send_frame(3);
      repeat (4) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0 || st_q.size() != 0) begin
         n_err++;
         $display("FAIL pre_next_drain: got %0d bytes/%0d status pending, want 0/0", exp_q.size(), st_q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      exp_byte_t e;
      int        st;
      build_gen_frame(11);
      repeat (7) drive(1'b1, 8'h55, 1'b1);
      drive(1'b1, 8'hD5, 1'b1);
      for (int k = 0; k < 30; k++) begin
         if (k >= 4) begin
            e.data = fbuf[k-4];
            e.sop  = (k == 4);
            exp_q.push_back(e);
         end
         drive(1'b1, fbuf[k], 1'b1);
      end
      drive(1'b1, fbuf[30], 1'b0);
      m_good = 16'd0;
      m_bad  = 16'd0;
      m_pre  = 16'd0;
      st = 0;                    // 0 idle, 1 preamble, 2 drop
      for (int k = 31; k < fbuf.size(); k++) begin
         drive(1'b1, fbuf[k], 1'b1);
         if (k == 31) begin
            @(negedge clk);
            n_vec += 4;
            if (out_valid !== 1'b0)  begin n_err++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
            if (frame_ok !== 1'b0)   begin n_err++; $display("FAIL rst_mid_frame_ok: got %b want 0", frame_ok); end
            if (frame_len !== 16'h0) begin n_err++; $display("FAIL rst_mid_frame_len: got %h want 0000", frame_len); end
            if (good_cnt !== 16'h0)  begin n_err++; $display("FAIL rst_mid_good_cnt: got %h want 0000", good_cnt); end
         end
         case (st)
            0: if (fbuf[k] == 8'h55) st = 1; else begin st = 2; m_pre = m_pre + 16'd1; end
            1: if (fbuf[k] != 8'h55 && fbuf[k] != 8'hD5) begin st = 2; m_pre = m_pre + 16'd1; end
            default: st = 2;
         endcase
      end
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      n_vec += 2;
      if (pre_err_cnt !== (STATS ? m_pre : 16'h0)) begin
         n_err++;
         $display("FAIL rst_mid_pre_err_cnt: got %h want %h", pre_err_cnt, STATS ? m_pre : 16'h0);
      end
      if (exp_q.size() != 0 || st_q.size() != 0) begin
         n_err++;
         $display("FAIL rst_mid_drain: got %0d bytes/%0d status pending, want 0/0", exp_q.size(), st_q.size());
      end
      build_gen_frame(3);
      send_frame(3);
      repeat (4) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0 || st_q.size() != 0) begin
         n_err++;
         $display("FAIL rst_next_drain: got %0d bytes/%0d status pending, want 0/0", exp_q.size(), st_q.size());
      end
   endtask

   task automatic test_back_to_back();
      build_gen_frame(3);
      send_frame(1);
      build_gen_frame(50);
      send_frame(1);
      repeat (4) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0 || st_q.size() != 0) begin
         n_err++;
         $display("FAIL b2b_drain: got %0d bytes/%0d status pending, want 0/0", exp_q.size(), st_q.size());
      end
   endtask

   initial begin
      fork
         forever begin
            exp_byte_t e;
            exp_stat_t s;
            @(negedge clk);
            if (out_valid === 1'b1) begin
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL out_unexpected: got byte %h sop %b, want no output", out_data, out_sop);
               end else begin
                  e = exp_q.pop_front();
                  if (out_data !== e.data || out_sop !== e.sop) begin
                     n_err++;
                     $display("FAIL out_byte: got %h sop %b, want %h sop %b", out_data, out_sop, e.data, e.sop);
                  end
               end
            end
            if (frame_done === 1'b1) begin
               n_vec++;
               if (st_q.size() == 0) begin
                  n_err++;
                  $display("FAIL done_unexpected: got frame_done 1, want 0");
               end else begin
                  s = st_q.pop_front();
                  n_vec += 2;
                  if ({frame_ok, crc_err, runt_err, giant_err} !== {s.ok, s.crc, s.runt, s.giant}) begin
                     n_err++;
                     $display("FAIL status_flags: got ok/crc/runt/giant %b, want %b",
                              {frame_ok, crc_err, runt_err, giant_err}, {s.ok, s.crc, s.runt, s.giant});
                  end
                  if (frame_len !== s.len) begin
                     n_err++;
                     $display("FAIL frame_len: got %0d want %0d", frame_len, s.len);
                  end
                  if ({good_cnt, bad_cnt, pre_err_cnt} !== (STATS ? {s.good, s.bad, s.pre} : 48'h0)) begin
                     n_err++;
                     $display("FAIL counters: got good/bad/pre %0d/%0d/%0d, want %0d/%0d/%0d",
                              good_cnt, bad_cnt, pre_err_cnt,
                              STATS ? s.good : 16'h0, STATS ? s.bad : 16'h0, STATS ? s.pre : 16'h0);
                  end
               end
            end
         end
      join_none

      test_reset();
      test_good_frame();
      test_crc_error();
      test_runt();
      test_giant();
      test_preamble_error();
      test_reset_mid_frame();
      test_back_to_back();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/eth_rx_frame_check.md
# eth_rx_frame_check

Receive-side Ethernet frame checker that sits directly downstream of the hardcoded UDP packet generator in byte mode (or any GMII-style byte source). It consumes the `rx_dv`/`rxd` byte stream and locates the preamble and SFD. It then streams the frame body with the 4-byte FCS stripped, verifies the CRC32, and reports per-frame status. It is used as a loopback sink for generator bring-up.

## Interface
- `MIN_FRAME`, default 64: minimum legal frame length in bytes, DA through FCS inclusive.
- `MAX_FRAME`, default 1518: maximum legal frame length in bytes.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1  clock.
- `nrst`  in  1  reset; synchronous, active-low.
- `rx_dv`  in  1  input byte valid; high for preamble, SFD, frame and FCS.
- `rxd`  in  8  input byte.
- `out_valid`  out  1  `out_data` valid; payload byte, FCS excluded.
- `out_data`  out  8  payload byte.
- `out_sop`  out  1  first payload byte of a frame; qualified by `out_valid`.
- `frame_done`  out  1  one-cycle pulse; the frame has ended and the status outputs are valid.
- `frame_ok`  out  1  no CRC, runt or giant error.
- `crc_err`, `runt_err`, `giant_err`  out  1 each  error flags.
- `frame_len`  out  16  bytes after the SFD, FCS included; saturates at 0xFFFF.
- `good_cnt`, `bad_cnt`  out  `CNT_W`  statistics counters.
- `pre_err_cnt`  out  `CNT_W`  statistics counter for preamble errors.

## Operation
- State machine states are IDLE, PREAMBLE, DATA and DROP.
- In IDLE:
  - `rx_dv`=1 with `rxd`=0x55 goes to PREAMBLE.
  - `rx_dv`=1 with any other byte goes to DROP and increments `pre_err_cnt`.
- In PREAMBLE:
  - 0x55 stays in PREAMBLE.
  - 0xD5 goes to DATA; the CRC is set to 0xFFFFFFFF and the length counter to 0.
  - Any other byte goes to DROP and increments `pre_err_cnt`.
  - `rx_dv`=0 goes to IDLE silently.
- In DATA:
  - Each byte with `rx_dv`=1 updates the CRC and increments `frame_len`.
  - Each byte is pushed into a 4-byte delay line. Once the delay line is full, each push emits the oldest byte to `out_data`.
  - `out_sop` is set on the first emitted byte of the frame.
- Frame end: `rx_dv`=0 while in DATA.
  - The state goes to IDLE and `frame_done` is pulsed.
  - The delay line contents (the FCS) are discarded.
- Error conditions:
  - `crc_err` is set when the raw CRC register ≠ 0xDEBB20E3.
  - `runt_err` is set when `frame_len` < `MIN_FRAME`.
  - `giant_err` is set when `frame_len` > `MAX_FRAME`.
  - `frame_ok` = none of the three.
- Giant frames keep streaming; they are only flagged.
- Frames shorter than 5 bytes emit no data, but `frame_done` still pulses.
- DROP holds until `rx_dv`=0, then goes to IDLE. Nothing is emitted in DROP.
- `good_cnt` increments on `frame_done` when `frame_ok`=1.
- `bad_cnt` increments on `frame_done` when `frame_ok`=0.
- All counters wrap.
- CRC is reflected CRC-32: polynomial 0xEDB88320, LSB first, initial value 0xFFFFFFFF, no final inversion before the residue compare.

## Timing
- Reset values: every output 0, state IDLE, delay line empty, CRC 0xFFFFFFFF.
- Reset mid-frame aborts the frame with no `frame_done`.
  - If `rx_dv` is still high after release, the block goes to DROP, unless the current byte is 0x55.
- Payload latency: frame byte k is sampled at edge n. It appears on `out_data` after the edge that samples byte k+4.
- `frame_done`, the status flags and `frame_len` are registered. They become valid after the edge that samples `rx_dv`=0.
  - The flags and `frame_len` hold until the next `frame_done`.
- Counters update on the same edge as `frame_done`.
- Back-to-back frames:
  - A single idle cycle (`rx_dv`=0) between frames is sufficient.
  - The next preamble byte is accepted on the cycle after `frame_done`.
- No backpressure: `out_valid` is a pure qualifier and the downstream must accept every cycle.

## Configuration
- `ETH_RX_CHECK_STATS_EN` defined: `good_cnt`, `bad_cnt` and `pre_err_cnt` are implemented.
- `ETH_RX_CHECK_STATS_EN` undefined: the three counter ports are tied to '0 and no counter flops are built. All other behaviour is identical.

## Structure
- Package `eth_rx_pkg` holds:
  - `PREAMBLE_BYTE` = 8'h55 and `SFD_BYTE` = 8'hD5
  - `CRC32_POLY` and `CRC32_INIT`
  - `CRC32_RESIDUE` = 32'hDEBB20E3
  - the state enum
  - the `frame_status_t` struct (ok, crc, runt, giant, len).
- Sub-module `crc32_d8`: a combinational 8-bit-per-cycle CRC32 next-state function (crc_in, data_in → crc_out). It is shared with the future TX FCS inserter.

## Test plan
- Generator frame: 7×0x55, 0xD5, then 64 bytes with FCS e3 8e df 1f → 60 output bytes, first 0xD8 with `out_sop`, last 0x01; `frame_ok`=1, `frame_len`=64, `good_cnt`=1.
- Same frame with byte 0x2E flipped to 0x2F → `crc_err`=1, `frame_ok`=0, `bad_cnt`=1; the 60 bytes are still streamed.
- 20-byte frame with valid CRC → `runt_err`=1, `crc_err`=0, 16 output bytes.
- Preamble 0x55, 0x55, 0x5D, … → DROP, no output, no `frame_done`, `pre_err_cnt`=1; the next good frame passes.
- `nrst` low for 1 cycle at byte 30 of a frame → outputs cleared, no `frame_done`, remainder dropped; the next frame gives `frame_ok`=1.
- Two generator frames separated by one idle cycle → two `frame_done` pulses, both ok, `good_cnt`=2.
